// File: rtl/player_move_multi_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : player_move_multi_if
//  Description : Control, peer-position and status bundle for the
//                per-player movement engine. The master side drives buttons,
//                game state and peer positions; the slave side is the mover.
//  Revision    : 1.0 - initial release
// ============================================================================
interface player_move_multi_if #(
    parameter int NUM_OTHERS = 3,
    parameter int COORD_W    = 9
);
    logic                            left;
    logic                            right;
    logic                            up;
    logic                            down;
    logic                            chop;
    logic                            carry;
    logic [2:0]                      game_state;
    logic [1:0]                      num_players;
    logic [1:0]                      local_player_ID;
    logic [NUM_OTHERS*COORD_W-1:0]   others_x;
    logic [NUM_OTHERS*COORD_W-1:0]   others_y;
    logic [NUM_OTHERS-1:0]           others_valid;
    logic [1:0]                      player_direction;
    logic [COORD_W-1:0]              player_loc_x;
    logic [COORD_W-1:0]              player_loc_y;
    logic                            moving;
    logic                            blocked;

    modport master (
        output left, right, up, down, chop, carry,
        output game_state, num_players, local_player_ID,
        output others_x, others_y, others_valid,
        input  player_direction, player_loc_x, player_loc_y, moving, blocked
    );

    modport slave (
        input  left, right, up, down, chop, carry,
        input  game_state, num_players, local_player_ID,
        input  others_x, others_y, others_valid,
        output player_direction, player_loc_x, player_loc_y, moving, blocked
    );
endinterface
`default_nettype wire

// File: rtl/player_move_multi.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : player_move_multi
//  Description : Per-frame player movement engine. Steps once per vsync
//                falling edge with hold-to-run acceleration, saturating
//                field clamps and four-direction box collision against peers.
//  Revision    : 1.0 - initial release
// ============================================================================
module player_move_multi #(
    parameter int NUM_OTHERS  = 3,
    parameter int COORD_W     = 9,
    parameter int X_MIN       = 144,
    parameter int X_MAX       = 464,
    parameter int Y_MIN       = 144,
    parameter int Y_MAX       = 304,
    parameter int BOX         = 32,
    parameter int STEP        = 4,
    parameter int RUN_STEP    = 8,
    parameter int RAMP_FRAMES = 16
) (
    input  wire logic         vsync,
    input  wire logic         reset,
    player_move_multi_if.slave io
);
    // One extra bit so that +step never wraps before the clamp sees it.
    localparam int W1 = COORD_W + 1;

    localparam logic [W1-1:0] XMIN_W    = W1'(X_MIN);
    localparam logic [W1-1:0] XMAX_W    = W1'(X_MAX);
    localparam logic [W1-1:0] YMIN_W    = W1'(Y_MIN);
    localparam logic [W1-1:0] YMAX_W    = W1'(Y_MAX);
    localparam logic [W1-1:0] BOX_W     = W1'(BOX);
    localparam logic [W1-1:0] STEP_W    = W1'(STEP);
    localparam logic [W1-1:0] RUN_W     = W1'(RUN_STEP);
    localparam logic [4:0]    RAMP_C    = 5'(RAMP_FRAMES);

    localparam logic [1:0]    DIR_LEFT  = 2'd0;
    localparam logic [1:0]    DIR_RIGHT = 2'd1;
    localparam logic [1:0]    DIR_UP    = 2'd2;
    localparam logic [1:0]    DIR_DOWN  = 2'd3;
    localparam logic [2:0]    GS_PLAY   = 3'd2;

    // Unsigned distance between two widened coordinates.
    function automatic logic [W1-1:0] abs_diff(input logic [W1-1:0] a,
                                               input logic [W1-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    logic [COORD_W-1:0] pos_x;
    logic [COORD_W-1:0] pos_y;
    logic [1:0]         direction;
    logic               moving_q;
    logic               blocked_q;
    logic [4:0]         run_cnt;
    logic [1:0]         prev_dir;
    logic               prev_valid;

    logic [COORD_W-1:0] spawn_x;
    logic [COORD_W-1:0] spawn_y;
    logic               active;
    logic               req_any;
    logic [1:0]         req_dir;
    logic               req_horiz;
    logic [4:0]         cnt_next;
    logic [W1-1:0]      step;
    logic [W1-1:0]      cur_x;
    logic [W1-1:0]      cur_y;
    logic [W1-1:0]      tgt_x;
    logic [W1-1:0]      tgt_y;
    logic               pos_changes;
    logic [NUM_OTHERS-1:0] peer_block;
    logic               any_block;

    // Spawn slot from the player count and this player's index; any index
    // outside the current player count falls back to the field centre.
    always_comb begin
        spawn_x = COORD_W'(304);
        spawn_y = COORD_W'(208);
        case ({io.num_players, io.local_player_ID})
            4'b01_00: begin spawn_x = COORD_W'(208); spawn_y = COORD_W'(208); end
            4'b01_01: begin spawn_x = COORD_W'(400); spawn_y = COORD_W'(208); end
            4'b10_00: begin spawn_x = COORD_W'(304); spawn_y = COORD_W'(176); end
            4'b10_01: begin spawn_x = COORD_W'(208); spawn_y = COORD_W'(272); end
            4'b10_10: begin spawn_x = COORD_W'(400); spawn_y = COORD_W'(272); end
            4'b11_00: begin spawn_x = COORD_W'(208); spawn_y = COORD_W'(176); end
            4'b11_01: begin spawn_x = COORD_W'(400); spawn_y = COORD_W'(176); end
            4'b11_10: begin spawn_x = COORD_W'(208); spawn_y = COORD_W'(272); end
            4'b11_11: begin spawn_x = COORD_W'(400); spawn_y = COORD_W'(272); end
            default:  begin spawn_x = COORD_W'(304); spawn_y = COORD_W'(208); end
        endcase
    end

    // Request decode (up > down > left > right), run ramp and step size.
    always_comb begin
        active    = (io.game_state == GS_PLAY) && !io.chop;
        req_any   = io.up | io.down | io.left | io.right;
        if (io.up)        req_dir = DIR_UP;
        else if (io.down) req_dir = DIR_DOWN;
        else if (io.left) req_dir = DIR_LEFT;
        else              req_dir = DIR_RIGHT;
        req_horiz = (req_dir == DIR_LEFT) || (req_dir == DIR_RIGHT);

        if (prev_valid && (prev_dir == req_dir))
            cnt_next = (run_cnt >= RAMP_C) ? RAMP_C : run_cnt + 5'd1;
        else
            cnt_next = 5'd0;

        step = ((cnt_next == RAMP_C) && !io.carry) ? RUN_W : STEP_W;
    end

    // Clamped target position; subtraction is guarded so it never wraps.
    always_comb begin
        cur_x = {1'b0, pos_x};
        cur_y = {1'b0, pos_y};
        tgt_x = cur_x;
        tgt_y = cur_y;
        case (req_dir)
            DIR_LEFT:  tgt_x = (cur_x < XMIN_W + step) ? XMIN_W : cur_x - step;
            DIR_RIGHT: tgt_x = (cur_x + step > XMAX_W) ? XMAX_W : cur_x + step;
            DIR_UP:    tgt_y = (cur_y < YMIN_W + step) ? YMIN_W : cur_y - step;
            default:   tgt_y = (cur_y + step > YMAX_W) ? YMAX_W : cur_y + step;
        endcase
        pos_changes = (tgt_x != cur_x) || (tgt_y != cur_y);
    end

    // Per-peer box test. A peer that already overlaps us only blocks moves
    // that bring us closer along the moved axis, so overlaps can be escaped.
    generate
        for (genvar i = 0; i < NUM_OTHERS; i++) begin : g_peer
            logic [W1-1:0] ox;
            logic [W1-1:0] oy;
            logic [W1-1:0] dx_t;
            logic [W1-1:0] dy_t;
            logic [W1-1:0] dx_c;
            logic [W1-1:0] dy_c;
            logic          hit_t;
            logic          hit_c;
            logic          moving_away;

            assign ox          = {1'b0, io.others_x[i*COORD_W +: COORD_W]};
            assign oy          = {1'b0, io.others_y[i*COORD_W +: COORD_W]};
            assign dx_t        = abs_diff(tgt_x, ox);
            assign dy_t        = abs_diff(tgt_y, oy);
            assign dx_c        = abs_diff(cur_x, ox);
            assign dy_c        = abs_diff(cur_y, oy);
            assign hit_t       = (dx_t < BOX_W) && (dy_t < BOX_W);
            assign hit_c       = (dx_c < BOX_W) && (dy_c < BOX_W);
            assign moving_away = req_horiz ? (dx_t >= dx_c) : (dy_t >= dy_c);
            assign peer_block[i] = io.others_valid[i] && hit_t
                                   && !(hit_c && moving_away);
        end
    endgenerate

    assign any_block = |peer_block;

    // Frame update on the falling edge of vsync; reset wins over everything.
    always_ff @(negedge vsync) begin
        if (reset) begin
            pos_x      <= spawn_x;
            pos_y      <= spawn_y;
            direction  <= DIR_DOWN;
            moving_q   <= 1'b0;
            blocked_q  <= 1'b0;
            run_cnt    <= 5'd0;
            prev_dir   <= DIR_DOWN;
            prev_valid <= 1'b0;
        end else if (!active || !req_any) begin
            moving_q   <= 1'b0;
            blocked_q  <= 1'b0;
            run_cnt    <= 5'd0;
            prev_valid <= 1'b0;
        end else begin
            direction  <= req_dir;
            prev_dir   <= req_dir;
            prev_valid <= 1'b1;
            if (any_block) begin
                moving_q  <= 1'b0;
                blocked_q <= 1'b1;
                run_cnt   <= 5'd0;
            end else begin
                pos_x     <= tgt_x[COORD_W-1:0];
                pos_y     <= tgt_y[COORD_W-1:0];
                moving_q  <= pos_changes;
                blocked_q <= 1'b0;
                run_cnt   <= cnt_next;
            end
        end
    end

    assign io.player_direction = direction;
    assign io.player_loc_x     = pos_x;
    assign io.player_loc_y     = pos_y;
    assign io.moving           = moving_q;
    assign io.blocked          = blocked_q;

endmodule
`default_nettype wire

// File: tb/tb_player_move_multi.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_player_move_multi
//  Description : Self-checking bench for player_move_multi. Expected frame
//                results are queued when a frame is driven and compared after
//                the vsync falling edge that produces them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_player_move_multi;
    localparam int NO = 3;
    localparam int CW = 9;

    typedef struct {
        string tag;
        int    x;
        int    y;
        int    dir;
        int    mov;
        int    blk;
    } exp_t;

    logic vsync = 1'b0;
    logic reset = 1'b1;
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    player_move_multi_if #(.NUM_OTHERS(NO), .COORD_W(CW)) bus ();

    player_move_multi dut (
        .vsync (vsync),
        .reset (reset),
        .io    (bus)
    );

    // Frame clock.
    always #5 vsync = ~vsync;

    // Hard stop in case the run never reaches its summary.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic set_btn(input logic u, input logic d, input logic l, input logic r);
        bus.up    = u;
        bus.down  = d;
        bus.left  = l;
        bus.right = r;
    endtask

    task automatic set_peer(input int slot, input int px, input int py, input logic [NO-1:0] vld);
        bus.others_x = '0;
        bus.others_y = '0;
        bus.others_x[slot*CW +: CW] = CW'(px);
        bus.others_y[slot*CW +: CW] = CW'(py);
        bus.others_valid = vld;
    endtask

    // Queue the expectation, let one frame edge pass, then compare.
    task automatic run_frame(input string tag, input int ex, input int ey,
                             input int ed, input int em, input int eb);
        exp_t e;
        e = '{tag, ex, ey, ed, em, eb};
        sb.push_back(e);
        @(negedge vsync);
        #1;
        e = sb.pop_front();
        check_val({e.tag, ".x"},   int'(bus.player_loc_x),     e.x);
        check_val({e.tag, ".y"},   int'(bus.player_loc_y),     e.y);
        check_val({e.tag, ".dir"}, int'(bus.player_direction), e.dir);
        check_val({e.tag, ".mov"}, int'(bus.moving),           e.mov);
        check_val({e.tag, ".blk"}, int'(bus.blocked),          e.blk);
    endtask

    task automatic do_reset(input int np, input int id, input int ex, input int ey);
        reset = 1'b1;
        bus.num_players     = 2'(np);
        bus.local_player_ID = 2'(id);
        run_frame($sformatf("reset_np%0d_id%0d", np, id), ex, ey, 3, 0, 0);
        reset = 1'b0;
    endtask

    // Collision table: button, peer position, slot, direction, free target.
    int c_btn  [4] = '{2, 3, 0, 1};
    int c_px   [4] = '{304, 304, 272, 336};
    int c_py   [4] = '{176, 240, 208, 208};
    int c_slot [4] = '{0, 2, 1, 0};
    int c_fx   [4] = '{304, 304, 300, 308};
    int c_fy   [4] = '{204, 212, 208, 208};

    initial begin
        int x;
        bus.game_state      = 3'd2;
        bus.chop            = 1'b0;
        bus.carry           = 1'b0;
        bus.num_players     = 2'd0;
        bus.local_player_ID = 2'd0;
        bus.others_x        = '0;
        bus.others_y        = '0;
        bus.others_valid    = '0;
        set_btn(0, 0, 0, 0);

        // Spawn table, including an out-of-range index.
        do_reset(3, 2, 208, 272);
        do_reset(1, 3, 304, 208);
        do_reset(2, 1, 208, 272);

        // Walk-to-run on a held right button, then carry / chop / pause.
        do_reset(0, 0, 304, 208);
        run_frame("idle", 304, 208, 3, 0, 0);
        set_btn(0, 0, 0, 1);
        for (int f = 1; f <= 20; f++) begin
            x = (f <= 16) ? 304 + 4 * f : 368 + 8 * (f - 16);
            run_frame($sformatf("run%0d", f), x, 208, 1, 1, 0);
        end
        bus.carry = 1'b1;
        run_frame("carry", 404, 208, 1, 1, 0);
        bus.carry = 1'b0;
        run_frame("uncarry", 412, 208, 1, 1, 0);
        bus.chop = 1'b1;
        run_frame("chop", 412, 208, 1, 0, 0);
        bus.chop = 1'b0;
        run_frame("after_chop", 416, 208, 1, 1, 0);
        bus.game_state = 3'd3;
        run_frame("pause", 416, 208, 1, 0, 0);
        bus.game_state = 3'd2;
        run_frame("resume", 420, 208, 1, 1, 0);
        reset = 1'b1;
        run_frame("reset_mid", 304, 208, 3, 0, 0);
        reset = 1'b0;

        // Up to the top clamp with right also held (up has priority).
        set_btn(0, 0, 0, 0);
        do_reset(2, 0, 304, 176);
        set_btn(1, 0, 0, 1);
        for (int k = 1; k <= 8; k++)
            run_frame($sformatf("up%0d", k), 304, 176 - 4 * k, 2, 1, 0);
        run_frame("at_clamp", 304, 144, 2, 0, 0);

        // Collision in each direction, then the same move with no valid peer.
        for (int c = 0; c < 4; c++) begin
            set_btn(0, 0, 0, 0);
            set_peer(0, 0, 0, '0);
            do_reset(0, 0, 304, 208);
            set_peer(c_slot[c], c_px[c], c_py[c], NO'(1 << c_slot[c]));
            set_btn(c_btn[c] == 2, c_btn[c] == 3, c_btn[c] == 0, c_btn[c] == 1);
            run_frame($sformatf("blk%0d", c), 304, 208, c_btn[c], 0, 1);
            bus.others_valid = '0;
            run_frame($sformatf("free%0d", c), c_fx[c], c_fy[c], c_btn[c], 1, 0);
        end

        // Already-overlapping peer: moving away is allowed, moving closer is not.
        set_btn(0, 0, 0, 0);
        set_peer(0, 0, 0, '0);
        do_reset(0, 0, 304, 208);
        set_peer(0, 310, 210, 3'b001);
        set_btn(0, 0, 1, 0);
        run_frame("escape", 300, 208, 0, 1, 0);
        set_btn(0, 0, 0, 1);
        run_frame("reenter", 300, 208, 1, 0, 1);

        check_val("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
